// File: rtl/serdes_wr_burst.sv
// serdes_wr_burst: buffers packed serdes words in a first-word-fall-through
// FIFO and drains them as address + data write bursts. A flush pulse forces
// the final partial burst of a stream out.
module serdes_wr_burst #(
  parameter int OP_WIDTH   = 16,
  parameter int OUT_COUNT  = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  localparam int DATA_WIDTH     = OP_WIDTH * OUT_COUNT,
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  s_write_req,
  output logic                  s_write_ready,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_write_flush,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  output logic                  idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = 9;  // burst length 1..256
  localparam logic [ADDR_WIDTH-1:0] BPW = ADDR_WIDTH'(BYTES_PER_WORD);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  flush_q;
  logic                  push, pop;

  state_t                state_q;
  logic [LW-1:0]         len_q, len_d;
  logic [7:0]            beat_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic                  awvalid_q, wvalid_q, wlast_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  launch;

  // Ready comes only from the registered full flag; full_q resets high so
  // ready stays low until the first edge after reset release.
  assign s_write_ready = !full_q;
  assign push          = s_write_req && !full_q;
  assign pop           = wvalid_q && m_wready;
  assign count_d       = count_q + CW'(push) - CW'(pop);
  assign full_d        = (count_d == CW'(FIFO_DEPTH));

  assign idle    = (count_q == '0) && (state_q == S_IDLE) && !flush_q;
  assign launch  = (count_q >= CW'(BURST_LEN)) || (flush_q && (count_q != '0));
  assign len_d   = (count_q >= CW'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(count_q);

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_wvalid  = wvalid_q;
  assign m_wlast   = wlast_q;
  assign m_wdata   = mem_q[rd_ptr_q];

  // FIFO pointers, occupancy and full flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_write_data;
  end

  // Flush stays pending until the FIFO has fully drained with no burst open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    flush_q <= 1'b0;
    else if (s_write_flush)                          flush_q <= 1'b1;
    else if (state_q == S_IDLE && count_q == '0)     flush_q <= 1'b0;
  end

  // Burst FSM: latch length at issue, hold address phase, stream beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      next_addr_q <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_start && idle) next_addr_q <= cfg_base_addr;
          if (launch) begin
            len_q     <= len_d;
            awvalid_q <= 1'b1;
            awaddr_q  <= next_addr_q;
            awlen_q   <= 8'(len_d - 1'b1);
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            wlast_q   <= (len_q == LW'(1));
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_wready) begin
            if (wlast_q) begin
              wvalid_q    <= 1'b0;
              wlast_q     <= 1'b0;
              next_addr_q <= next_addr_q + ADDR_WIDTH'(len_q) * BPW;
              state_q     <= S_IDLE;
            end else begin
              beat_q  <= beat_q + 1'b1;
              wlast_q <= ((LW'(beat_q) + LW'(1)) == (len_q - LW'(1)));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_wr_burst.sv
// Bench for serdes_wr_burst: random word data, directed scenarios, and a
// stream-level reference model (words in order, chunked into bursts of 16
// with a final remainder, addresses advancing by len*20 bytes mod 2^32).
module tb_serdes_wr_burst;
  localparam int DW = 160;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int BPW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic          s_write_req = 1'b0;
  logic          s_write_ready;
  logic [DW-1:0] s_write_data = '0;
  logic          s_write_flush = 1'b0;
  logic          m_awvalid;
  logic          m_awready = 1'b1;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_wvalid;
  logic          m_wready = 1'b1;
  logic [DW-1:0] m_wdata;
  logic          m_wlast;
  logic          idle;

  serdes_wr_burst dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .s_write_req(s_write_req), .s_write_ready(s_write_ready), .s_write_data(s_write_data),
    .s_write_flush(s_write_flush), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; int cyc; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; int cyc; } w_t;

  aw_t           mon_aw[$];
  w_t            mon_w[$];
  logic [DW-1:0] mdl_words[$];
  logic [AW-1:0] mdl_addr = '0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rand_wready = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Write-data ready: random when requested, otherwise always accepting
  always @(negedge clk) m_wready = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Protocol monitor: captures handshakes and checks valid/stability rules
  logic          aw_pend = 1'b0, w_pend = 1'b0;
  logic [AW-1:0] pa;
  logic [7:0]    pl;
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end else begin
      if (aw_pend) chk("aw_stable", {m_awvalid, m_awaddr, m_awlen}, {1'b1, pa, pl});
      if (w_pend)  chk("wvalid_held", m_wvalid, 1'b1);
      if (m_awvalid || m_wvalid) chk("one_phase", m_awvalid && m_wvalid, 1'b0);
      aw_pend = m_awvalid && !m_awready;
      pa      = m_awaddr;
      pl      = m_awlen;
      w_pend  = m_wvalid && !(m_wready && m_wlast);
      if (m_awvalid && m_awready) mon_aw.push_back('{m_awaddr, m_awlen, cyc});
      if (m_wvalid && m_wready)   mon_w.push_back('{m_wdata, m_wlast, cyc});
    end
  end

  task automatic set_base(input logic [AW-1:0] a);
    @(negedge clk);
    cfg_start = 1'b1; cfg_base_addr = a;
    @(negedge clk);
    cfg_start = 1'b0;
    mdl_addr = a;
  endtask

  // Push n accepted words; optional flush with the last one and a junk
  // cfg_start on push index start_at (which must be ignored).
  task automatic push_words(input int n, input bit flush_last, input int start_at);
    int i = 0;
    int g = 0;
    logic [DW-1:0] w = rnd_word();
    while (i < n && g < 5000) begin
      @(negedge clk);
      s_write_req   = 1'b1;
      s_write_data  = w;
      s_write_flush = flush_last && (i == n - 1) && s_write_ready;
      cfg_start     = (i == start_at);
      cfg_base_addr = 32'h5555_0000;
      if (s_write_ready) begin
        mdl_words.push_back(w);
        i++;
        w = rnd_word();
      end
      g++;
    end
    if (i < n) chk("push_timeout", i, n);
    @(negedge clk);
    s_write_req = 1'b0; s_write_flush = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    s_write_flush = 1'b1;
    @(negedge clk);
    s_write_flush = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!idle && g < 3000);
    chk("idle_timeout", idle, 1'b1);
  endtask

  // Compare captured traffic against the stream model, then advance it
  task automatic verify(input bit timing);
    int n   = mdl_words.size();
    int nb  = (n + BL - 1) / BL;
    int idx = 0;
    chk("n_bursts", mon_aw.size(), nb);
    chk("n_beats", mon_w.size(), n);
    if (mon_aw.size() == nb && mon_w.size() == n) begin
      for (int k = 0; k < nb; k++) begin
        int len = (n - k * BL < BL) ? n - k * BL : BL;
        chk("awaddr", mon_aw[k].addr, mdl_addr);
        chk("awlen", mon_aw[k].len, len - 1);
        for (int b = 0; b < len; b++) begin
          chk("wdata", mon_w[idx].data, mdl_words[idx]);
          chk("wlast", mon_w[idx].last, b == len - 1);
          if (timing) chk("beat_cycle", mon_w[idx].cyc, mon_aw[k].cyc + 1 + b);
          idx++;
        end
        mdl_addr = mdl_addr + AW'(len * BPW);
      end
    end
    mon_aw.delete();
    mon_w.delete();
    mdl_words.delete();
  endtask

  initial begin
    int acc;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", s_write_ready, 1'b0);
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_awlen", m_awlen, 0);
    chk("rst_wvalid", m_wvalid, 1'b0);
    chk("rst_wlast", m_wlast, 1'b0);
    chk("rst_idle", idle, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_write_ready, 1'b1);

    // Single full burst with launch latency
    set_base(32'h1000);
    push_words(16, 1'b0, -1);
    chk("launch_early", m_awvalid, 1'b0);
    @(negedge clk);
    chk("launch", {m_awvalid, m_awaddr, m_awlen}, {1'b1, 32'h1000, 8'd15});
    wait_idle();
    verify(1'b1);
    chk("idle_after", idle, 1'b1);

    // Flush partial bursts: 7 then 9 words
    set_base(32'h1000);
    push_words(7, 1'b0, -1);
    pulse_flush();
    wait_idle();
    verify(1'b1);
    push_words(9, 1'b0, -1);
    pulse_flush();
    wait_idle();
    chk("flush2_addr", mdl_addr, 32'h108C);
    verify(1'b1);

    // Flush with empty FIFO: no burst, idle returns within 2 cycles
    @(negedge clk);
    s_write_flush = 1'b1;
    @(negedge clk);
    s_write_flush = 1'b0;
    chk("fe_awvalid1", m_awvalid, 1'b0);
    @(negedge clk);
    chk("fe_idle", idle, 1'b1);
    repeat (3) @(negedge clk);
    chk("fe_no_burst", mon_aw.size(), 0);

    // Flush in the same cycle as the 5th push
    push_words(5, 1'b1, -1);
    wait_idle();
    verify(1'b1);

    // Backpressure: address channel stalled, FIFO fills to 32
    m_awready = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      logic [DW-1:0] w = rnd_word();
      @(negedge clk);
      s_write_req = 1'b1;
      s_write_data = w;
      if (s_write_ready) begin
        mdl_words.push_back(w);
        acc++;
      end
    end
    chk("bp_accepted", acc, 32);
    chk("bp_ready_low", s_write_ready, 1'b0);
    m_awready = 1'b1;
    rand_wready = 1'b1;
    push_words(40 - acc, 1'b1, -1);
    wait_idle();
    rand_wready = 1'b0;
    verify(1'b0);

    // Address wrap with an ignored cfg_start mid-burst
    set_base(32'hFFFF_FFEC);
    push_words(32, 1'b0, 20);
    wait_idle();
    if (mon_aw.size() == 2 && mon_w.size() == 32) begin
      chk("wrap_addr2", mon_aw[1].addr, 32'h0000_012C);  // 2^32-20 + 320 = 300
      chk("b2b_gap", mon_aw[1].cyc - mon_w[15].cyc, 2);
    end
    verify(1'b1);

    // Reset during beat 5
    push_words(16, 1'b0, -1);
    begin
      int g = 0;
      while (mon_w.size() < 4 && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("beat5_reached", mon_w.size(), 4);
    end
    reset_n = 1'b0;
    #1;
    chk("mr_awvalid", m_awvalid, 1'b0);
    chk("mr_wvalid", m_wvalid, 1'b0);
    chk("mr_wlast", m_wlast, 1'b0);
    chk("mr_ready", s_write_ready, 1'b0);
    chk("mr_idle", idle, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_aw.delete();
    mon_w.delete();
    mdl_words.delete();
    mdl_addr = '0;
    @(negedge clk);
    chk("mr_ready_after", s_write_ready, 1'b1);
    push_words(16, 1'b0, -1);
    wait_idle();
    verify(1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
